sh_mem_arbiter: RTL and testbench
=================================

SH_MEM_ARBITER -- requirements
Module: sh_mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesting cores.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the shared-memory address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning the data/register width.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state on rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port enable, input, 2*NUM_REQ bits, the per-requester op (2'b00 none, 2'b01 read, 2'b10 write, 2'b11 none).
REQ-007 The block SHALL have port addr, input, ADDR_W*NUM_REQ bits, the per-requester address.
REQ-008 The block SHALL have port wr_data, input, DATA_W*NUM_REQ bits, the per-requester write data.
REQ-009 The block SHALL have port rd_data, output, DATA_W*NUM_REQ bits, the per-requester registered read data.
REQ-010 The block SHALL have port ready, output, NUM_REQ bits, a one-cycle per-requester completion pulse.
REQ-011 The block SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, DATA_W), the single-port memory request.
REQ-012 The block SHALL have port mem_rdata, input, DATA_W bits, memory read data valid exactly one cycle after mem_en with mem_we=0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-014 In IDLE with at least one eligible request (enable 01/10), the FSM SHALL latch the grant index, op, addr and wr_data, then go to ACCESS; with no eligible request it SHALL stay in IDLE.
REQ-015 Grant selection SHALL be round-robin: search starts at last_grant+1 modulo NUM_REQ, and the first eligible index wins.
REQ-016 In ACCESS the block SHALL drive mem_en=1, mem_we=1 for a write, and mem_addr/mem_wdata from the latched values, then go to RESP.
REQ-017 In RESP the block SHALL pulse ready[grant]=1 for one cycle, load rd_data[grant] from mem_rdata on a read, set last_grant=grant, and go to IDLE.
REQ-018 Latency SHALL be: request sampled in IDLE cycle N, memory access in N+1, ready in N+2; maximum throughput is one transaction per 3 cycles.
REQ-019 In the IDLE cycle immediately after RESP, the just-served requester SHALL be ineligible, so a held enable is not re-granted.
REQ-020 A requester SHALL keep enable, addr and wr_data stable until its ready pulse; the block latches in IDLE, so later changes do not affect the transaction in flight.
REQ-021 Outside ACCESS, mem_en and mem_we SHALL be 0; ready SHALL be 0 for all indices except the granted one in RESP.
REQ-022 rd_data[i] SHALL hold its value until requester i completes another read; writes SHALL NOT modify rd_data.
REQ-023 Code 2'b11 SHALL be treated as no request and never granted.

Reset
REQ-024 Asserting reset (low) SHALL immediately force state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), ready=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 and all rd_data=0.
REQ-025 Reset asserted mid-transaction SHALL abort it with no ready pulse; after release, arbitration SHALL restart from IDLE on the first rising edge.

Configuration
REQ-026 When macro SH_MEM_ARB_STATS_EN is defined, the block SHALL add output conflict_cnt (16 bits, reset 0), incremented by 1 in each IDLE cycle with two or more eligible requests and saturating at 16'hFFFF.
REQ-027 When SH_MEM_ARB_STATS_EN is undefined, conflict_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 Single write: requester 2 enable=10, addr=0x15, wr_data=0xA5 -> mem_en=1, mem_we=1, mem_addr=0x15, mem_wdata=0xA5 one cycle later; ready[2]=1 two cycles after sampling.
REQ-029 Single read: requester 1 enable=01, addr=0x15, memory returns 0xA5 -> rd_data[1]=0xA5 and ready[1]=1 in RESP; no other ready bit set.
REQ-030 Contention: all 4 requesters read continuously from reset -> grant order 0,1,2,3,0, one ready every 3 cycles; with STATS on, conflict_cnt increments once per grant cycle.
REQ-031 Held enable: requester 3 alone holds enable=01 after its ready pulse -> no grant in the masked IDLE cycle; re-granted on the following IDLE.
REQ-032 Reset mid-op: reset low during ACCESS -> mem_en=0 and ready=0 immediately; after release with requesters 0 and 2 pending -> requester 0 granted first.
REQ-033 Illegal code: requester 0 enable=11, requester 1 enable=00 -> state stays IDLE, mem_en never asserted.

Source files
------------

// File: rtl/sh_mem_arbiter_if.sv
// Request/response bundle between NUM_REQ cores, the arbiter and a single-port memory.
// The slave modport is the arbiter; the master modport is the cores-plus-memory side.
interface sh_mem_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
);
    logic [2*NUM_REQ-1:0]      enable;
    logic [ADDR_W*NUM_REQ-1:0] addr;
    logic [DATA_W*NUM_REQ-1:0] wr_data;
    logic [DATA_W*NUM_REQ-1:0] rd_data;
    logic [NUM_REQ-1:0]        ready;
    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport slave (
        input  enable, addr, wr_data, mem_rdata,
        output rd_data, ready, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output enable, addr, wr_data, mem_rdata,
        input  rd_data, ready, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sh_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ cores (IDLE/ACCESS/RESP).
// Define SH_MEM_ARB_STATS_EN to add the saturating conflict_cnt output.
module sh_mem_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic            clk,
    input  logic            reset,
    sh_mem_arbiter_if.slave bus
`ifdef SH_MEM_ARB_STATS_EN
    ,
    output logic [15:0]     conflict_cnt
`endif
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nxt;
    logic [GW-1:0]       grant, last_grant, pick, cand;
    logic                found, sel_we, we_q, mask_last;
    logic [ADDR_W-1:0]   sel_addr, addr_q;
    logic [DATA_W-1:0]   sel_wdata, wdata_q;
    logic [NUM_REQ-1:0]  elig;
    logic [ADDR_W-1:0]   req_addr  [NUM_REQ];
    logic [DATA_W-1:0]   req_wdata [NUM_REQ];
    logic                req_we    [NUM_REQ];

    // Codes 01/10 are requests; the requester served last is skipped for one IDLE cycle.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        logic [DATA_W-1:0] rd_q;

        assign req_addr[i]  = bus.addr[i*ADDR_W +: ADDR_W];
        assign req_wdata[i] = bus.wr_data[i*DATA_W +: DATA_W];
        assign req_we[i]    = bus.enable[2*i+1];
        assign elig[i]      = (bus.enable[2*i] ^ bus.enable[2*i+1]) &&
                              !(mask_last && last_grant == GW'(i));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) rd_q <= '0;
            else if (state == RESP && !we_q && grant == GW'(i)) rd_q <= bus.mem_rdata;
        end
        assign bus.rd_data[i*DATA_W +: DATA_W] = rd_q;
    end

    always_comb begin
        found     = 1'b0;
        pick      = '0;
        cand      = '0;
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && elig[cand]) begin
                found     = 1'b1;
                pick      = cand;
                sel_we    = req_we[cand];
                sel_addr  = req_addr[cand];
                sel_wdata = req_wdata[cand];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
        bus.ready  = '0;
        unique case (state)
            IDLE:   if (found) state_nxt = ACCESS;
            ACCESS: begin
                bus.mem_en = 1'b1;
                bus.mem_we = we_q;
                state_nxt  = RESP;
            end
            RESP: begin
                bus.ready[grant] = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant      <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_last  <= 1'b0;
        end else begin
            mask_last <= (state == RESP);
            if (state == IDLE && found) begin
                grant   <= pick;
                we_q    <= sel_we;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state == RESP) last_grant <= grant;
        end
    end

`ifdef SH_MEM_ARB_STATS_EN
    // Contention means two or more requests still eligible after masking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) conflict_cnt <= '0;
        else if (state == IDLE && |(elig & (elig - NUM_REQ'(1))) && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sh_mem_arbiter.sv
// Bench for sh_mem_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_sh_mem_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sh_mem_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef SH_MEM_ARB_STATS_EN
    logic [15:0] conflict_cnt;
`endif

    sh_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SH_MEM_ARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    // Memory the DUT talks to: synchronous write, read data one cycle after mem_en.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Reference model: one transaction occupies 3 cycles; phase counts through it.
    int            m_phase, m_g, m_last, m_excl;
    bit            m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] rd_exp  [NR];
    logic [DW-1:0] ref_mem [2**AW];
    logic [15:0]   m_conf;

    logic [1:0]    en_v   [NR];
    logic [AW-1:0] addr_v [NR];
    logic [DW-1:0] wd_v   [NR];
    bit            active [NR];
    bit            hold   [NR];
    bit            rnd_mode = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_g = 0; m_last = NR - 1; m_excl = -1; m_conf = '0;
        for (int i = 0; i < NR; i++) rd_exp[i] = '0;
    endtask

    task automatic model_step();
        int cnt, pick, j;
        if (m_phase == 0) begin
            cnt = 0; pick = -1;
            for (int k = 1; k <= NR; k++) begin
                j = (m_last + k) % NR;
                if ((en_v[j] == 2'b01 || en_v[j] == 2'b10) && j != m_excl) begin
                    cnt++;
                    if (pick < 0) pick = j;
                end
            end
            if (cnt >= 2 && m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
            m_excl = -1;
            if (pick >= 0) begin
                m_g = pick; m_we = (en_v[pick] == 2'b10);
                m_addr = addr_v[pick]; m_wd = wd_v[pick]; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            if (m_we) ref_mem[m_addr] = m_wd;
            else      rd_exp[m_g] = ref_mem[m_addr];
            m_last = m_g; m_excl = m_g; m_phase = 0;
        end
    endtask

    task automatic check_outputs();
        chk("mem_en", bus.mem_en, m_phase == 1);
        chk("mem_we", bus.mem_we, m_phase == 1 && m_we);
        if (m_phase == 1) begin
            chk("mem_addr", bus.mem_addr, m_addr);
            if (m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
        end
        chk("ready", bus.ready, (m_phase == 2) ? (64'd1 << m_g) : 64'd0);
        for (int i = 0; i < NR; i++) chk($sformatf("rd_data%0d", i), bus.rd_data[i*DW +: DW], rd_exp[i]);
`ifdef SH_MEM_ARB_STATS_EN
        chk("conflict_cnt", conflict_cnt, m_conf);
`endif
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.enable[2*i +: 2]    = en_v[i];
            bus.addr[i*AW +: AW]    = addr_v[i];
            bus.wr_data[i*DW +: DW] = wd_v[i];
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] code, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit h);
        en_v[i] = code; addr_v[i] = a; wd_v[i] = d; hold[i] = h;
        active[i] = (code == 2'b01 || code == 2'b10);
    endtask

    task automatic update_stim();
        int r;
        for (int i = 0; i < NR; i++) begin
            if (m_phase == 2 && m_g == i && !hold[i]) begin
                active[i] = 1'b0; en_v[i] = 2'b00;
            end
            if (rnd_mode && !active[i]) begin
                r = $urandom_range(0, 9);
                if (r < 2)      set_req(i, (r == 0) ? 2'b01 : 2'b10, AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
                else if (r < 4) set_req(i, (r == 2) ? 2'b11 : 2'b00, AW'($urandom_range(0, 15)), DW'($urandom), 1'b0);
            end
        end
    endtask

    task automatic cycle(input int n);
        for (int c = 0; c < n; c++) begin
            update_stim(); drive(); model_step();
            @(negedge clk);
            check_outputs();
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NR; i++) set_req(i, 2'b00, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_ready", bus.ready, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        @(negedge clk);
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        bus.mem_rdata = '0;
        for (int i = 0; i < 2**AW; i++) begin
            mem[i] = DW'($urandom); ref_mem[i] = mem[i];
        end
        clear_reqs(); drive();
        @(negedge clk);
        do_reset();

        // Illegal and idle codes are never granted.
        set_req(0, 2'b11, 8'h33, 8'h44, 1'b0);
        set_req(1, 2'b00, 8'h15, 8'h55, 1'b0);
        cycle(5);
        clear_reqs();

        // Single write from requester 2, then single read of the same word by requester 1.
        set_req(2, 2'b10, 8'h15, 8'hA5, 1'b0);
        cycle(5);
        set_req(1, 2'b01, 8'h15, 8'h00, 1'b0);
        cycle(5);
        chk("read_back", bus.rd_data[1*DW +: DW], 8'hA5);

        // All four read continuously from reset.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 2'b01, AW'(i + 3), '0, 1'b1);
        cycle(16);
        clear_reqs();
        cycle(4);

        // Requester 3 alone holds its read enable.
        set_req(3, 2'b01, 8'h07, '0, 1'b1);
        cycle(14);
        clear_reqs();
        cycle(4);

        // Reset during ACCESS, requesters 0 and 2 pending.
        set_req(2, 2'b01, 8'h02, '0, 1'b1);
        cycle(1);
        set_req(0, 2'b01, 8'h09, '0, 1'b1);
        begin
            int guard = 0;
            while (m_phase != 1 && guard < 8) begin cycle(1); guard++; end
            chk("reach_access", m_phase, 1);
        end
        do_reset();
        cycle(1);
        chk("grant_after_rst", m_g, 0);
        cycle(8);
        clear_reqs();
        cycle(4);

        // Random traffic.
        rnd_mode = 1'b1;
        cycle(800);
        rnd_mode = 1'b0;
        clear_reqs();
        cycle(6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
